// File: rtl/protocol_out.sv
// Host-bound nibble encoder: sends a byte as {CMD_LO,lo} then {CMD_HI,hi}
// over a valid/ready UART TX interface, with an idle gap in between.
module protocol_out #(
  parameter logic [3:0] CMD_LO     = 4'b0001,
  parameter logic [3:0] CMD_HI     = 4'b0010,
  parameter int         GAP_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_send,
  input  logic [7:0] i_data,
  input  logic       i_tx_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_GAP,
    S_HI,
    S_DONE
  } state_t;

  localparam logic [7:0] GAP_LD =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     r_state;
  logic [7:0] r_data;
  logic [7:0] r_gap;
  logic       w_xfer;

  assign w_xfer = o_tx_valid && i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_data     <= 8'h00;
      r_gap      <= 8'h00;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_send) begin
            r_data     <= i_data;
            r_state    <= S_LO;
            o_tx_valid <= 1'b1;
            o_tx_data  <= {CMD_LO, i_data[3:0]};
            o_busy     <= 1'b1;
          end
        end
        S_LO: begin
          if (w_xfer) begin
            if (GAP_CYCLES > 0) begin
              r_state    <= S_GAP;
              r_gap      <= GAP_LD;
              o_tx_valid <= 1'b0;
            end else begin
              r_state   <= S_HI;
              o_tx_data <= {CMD_HI, r_data[7:4]};
            end
          end
        end
        // counter runs GAP_CYCLES-1 down to 0, one cycle each
        S_GAP: begin
          if (r_gap == 8'h00) begin
            r_state    <= S_HI;
            o_tx_valid <= 1'b1;
            o_tx_data  <= {CMD_HI, r_data[7:4]};
          end else begin
            r_gap <= r_gap - 8'h01;
          end
        end
        S_HI: begin
          if (w_xfer) begin
            r_state    <= S_DONE;
            o_tx_valid <= 1'b0;
            o_done     <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
